frame_scan_reader: RTL and testbench

FRAME_SCAN_READER -- requirements
Module: frame_scan_reader

---
 rtl/frame_scan_reader_pkg.sv | 31 +++
 rtl/frame_scan_reader_line_buffer_bank.sv | 30 +++
 rtl/frame_scan_reader.sv | 187 ++++++++++++++++++
 tb/tb_frame_scan_reader.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/frame_scan_reader_pkg.sv
// Shared constants, types and address helper for the frame scan reader.
// Holds the screen geometry, burst size, SRAM screen base table and pixel type.
package frame_scan_reader_pkg;

    localparam int SCREEN_W  = 320;
    localparam int SCREEN_H  = 240;
    localparam int BURST_LEN = 16;
    localparam int ADDR_W    = 18;

    // Word address of each screen buffer in SRAM; entry 3 is unused and aliases screen 0.
    localparam logic [2:0][ADDR_W-1:0] SCREEN_BASE = {18'd153600, 18'd76800, 18'd0};

    typedef logic [14:0] rgb555_t;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DATA
    } fetchState_t;

    function automatic logic [ADDR_W-1:0] lineBaseAddr(
        input logic [1:0] screen,
        input logic [7:0] lineY,
        input int         lineWords
    );
        logic [1:0] sel;
        sel = (screen == 2'd3) ? 2'd0 : screen;
        return SCREEN_BASE[sel] + ADDR_W'(lineY) * ADDR_W'(lineWords);
    endfunction

endpackage

// File: rtl/frame_scan_reader_line_buffer_bank.sv
// Two-bank line buffer: one bank is filled from SRAM while the other is displayed.
// Simple dual-port RAM, one write port and one synchronous read port.
module line_buffer_bank
    import frame_scan_reader_pkg::*;
#(
    parameter int DEPTH = 320,
    parameter int IDX_W = 9
) (
    input  logic             Clock,
    input  logic             WrEn,
    input  logic             WrBank,
    input  logic [IDX_W-1:0] WrIdx,
    input  rgb555_t          WrData,
    input  logic             RdBank,
    input  logic [IDX_W-1:0] RdIdx,
    output rgb555_t          RdData
);

    rgb555_t mem [2][DEPTH];

    // NOTE: the storage array has no reset; only control state needs a known value,
    // and leaving it out keeps the array mappable onto block RAM.
    always_ff @(posedge Clock) begin
        if (WrEn) begin
            mem[WrBank][WrIdx] <= WrData;
        end
        RdData <= mem[RdBank][RdIdx];
    end

endmodule

// File: rtl/frame_scan_reader.sv
// Prefetches one display line per LineStart from SRAM in bursts into a fill bank,
// while the other bank feeds PixelOut; banks swap on every LineStart.
module frame_scan_reader #(
    parameter int SCREEN_W  = frame_scan_reader_pkg::SCREEN_W,
    parameter int SCREEN_H  = frame_scan_reader_pkg::SCREEN_H,
    parameter int BURST_LEN = frame_scan_reader_pkg::BURST_LEN
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic [1:0]  ActiveScreen,
    input  logic        LineStart,
    input  logic [7:0]  LineY,
    input  logic [8:0]  PixelX,
    output logic [14:0] PixelOut,
    output logic        ReqBurstRead,
    output logic [17:0] RdAddress,
    input  logic        AddrValid,
    input  logic        RdDataValid,
    input  logic [15:0] RdData,
    output logic        Busy,
    output logic        Underrun
);

    import frame_scan_reader_pkg::*;

    localparam int NUM_BURSTS = SCREEN_W / BURST_LEN;
    localparam int IDX_W      = $clog2(SCREEN_W);
    localparam int WORD_W     = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam int BURST_W    = (NUM_BURSTS > 1) ? $clog2(NUM_BURSTS) : 1;

    fetchState_t        state;
    fetchState_t        stateNext;
    logic               displayBank;
    logic [WORD_W-1:0]  wordCnt;
    logic [BURST_W-1:0] burstCnt;
    logic               restartPending;
    logic               pendValid;
    logic [ADDR_W-1:0]  pendBase;
    logic               pixelValid;

    logic               lineYValid;
    logic [ADDR_W-1:0]  newBase;
    logic               wordTaken;
    logic               lastWord;
    logic               lastBurst;
    logic               restartAny;
    logic               restartValid;
    logic [ADDR_W-1:0]  restartBase;
    logic               loadEn;
    logic [ADDR_W-1:0]  loadAddr;
    logic               nextBurst;

    logic               wrEn;
    logic [IDX_W-1:0]   wrIdx;
    logic               pixelInRange;
    logic [IDX_W-1:0]   rdIdx;
    rgb555_t            bankData;
    logic               unusedRdBit;

    assign lineYValid   = 32'(LineY) < SCREEN_H;
    assign newBase      = lineBaseAddr(ActiveScreen, LineY, SCREEN_W);
    assign wordTaken    = (state == DATA) && RdDataValid;
    assign lastWord     = wordTaken && (wordCnt == WORD_W'(BURST_LEN - 1));
    assign lastBurst    = burstCnt == BURST_W'(NUM_BURSTS - 1);

    // A LineStart seen while busy (now or earlier) redirects the fetch once the in-flight burst drains.
    assign restartAny   = restartPending || LineStart;
    assign restartValid = LineStart ? lineYValid : pendValid;
    assign restartBase  = LineStart ? newBase : pendBase;

    // NOTE: every output of this block gets a default before the case, so no latch is inferred.
    always_comb begin
        stateNext = state;
        loadEn    = 1'b0;
        loadAddr  = '0;
        nextBurst = 1'b0;
        case (state)
            IDLE: begin
                if (LineStart && lineYValid) begin
                    stateNext = REQ;
                    loadEn    = 1'b1;
                    loadAddr  = newBase;
                end
            end
            REQ: begin
                if (AddrValid) begin
                    stateNext = DATA;
                end
            end
            DATA: begin
                if (lastWord) begin
                    if (restartAny) begin
                        if (restartValid) begin
                            stateNext = REQ;
                            loadEn    = 1'b1;
                            loadAddr  = restartBase;
                        end else begin
                            stateNext = IDLE;
                        end
                    end else if (lastBurst) begin
                        stateNext = IDLE;
                    end else begin
                        stateNext = REQ;
                        nextBurst = 1'b1;
                    end
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state          <= IDLE;
            displayBank    <= 1'b0;
            wordCnt        <= '0;
            burstCnt       <= '0;
            RdAddress      <= '0;
            restartPending <= 1'b0;
            pendValid      <= 1'b0;
            pendBase       <= '0;
            Underrun       <= 1'b0;
            pixelValid     <= 1'b0;
        end else begin
            state      <= stateNext;
            pixelValid <= pixelInRange;

            if (LineStart) begin
                displayBank <= ~displayBank;
            end

            if (LineStart && state != IDLE) begin
                Underrun <= 1'b1;
            end

            if (wordTaken) begin
                wordCnt <= lastWord ? '0 : wordCnt + 1'b1;
            end

            if (loadEn) begin
                RdAddress <= loadAddr;
                burstCnt  <= '0;
            end else if (nextBurst) begin
                RdAddress <= RdAddress + ADDR_W'(BURST_LEN);
                burstCnt  <= burstCnt + 1'b1;
            end

            if (lastWord) begin
                restartPending <= 1'b0;
            end else if (LineStart && state != IDLE) begin
                restartPending <= 1'b1;
                pendValid      <= lineYValid;
                pendBase       <= newBase;
            end
        end
    end

    // Words of a burst that was overtaken by a new LineStart are dropped.
    assign wrEn  = wordTaken && !restartAny;
    assign wrIdx = IDX_W'(burstCnt) * IDX_W'(BURST_LEN) + IDX_W'(wordCnt);

    assign pixelInRange = 32'(PixelX) < SCREEN_W;
    assign rdIdx        = pixelInRange ? IDX_W'(PixelX) : '0;

    // Bit 15 of each SRAM word carries no pixel data.
    assign unusedRdBit  = RdData[15];

    line_buffer_bank #(
        .DEPTH (SCREEN_W),
        .IDX_W (IDX_W)
    ) u_lineBuffer (
        .Clock  (Clock),
        .WrEn   (wrEn),
        .WrBank (~displayBank),
        .WrIdx  (wrIdx),
        .WrData (RdData[14:0]),
        .RdBank (displayBank),
        .RdIdx  (rdIdx),
        .RdData (bankData)
    );

    assign PixelOut     = pixelValid ? bankData : '0;
    assign ReqBurstRead = (state == REQ);
    assign Busy         = (state != IDLE);

endmodule

// File: tb/tb_frame_scan_reader.sv
// Scoreboard bench for frame_scan_reader with a burst SRAM controller model.
module tb_frame_scan_reader;

    logic        Clock = 1'b0;
    logic        Reset;
    logic [1:0]  ActiveScreen;
    logic        LineStart;
    logic [7:0]  LineY;
    logic [8:0]  PixelX;
    logic [14:0] PixelOut;
    logic        ReqBurstRead;
    logic [17:0] RdAddress;
    logic        AddrValid;
    logic        RdDataValid;
    logic [15:0] RdData;
    logic        Busy;
    logic        Underrun;

    always #5 Clock = ~Clock;

    frame_scan_reader dut (
        .Clock        (Clock),
        .Reset        (Reset),
        .ActiveScreen (ActiveScreen),
        .LineStart    (LineStart),
        .LineY        (LineY),
        .PixelX       (PixelX),
        .PixelOut     (PixelOut),
        .ReqBurstRead (ReqBurstRead),
        .RdAddress    (RdAddress),
        .AddrValid    (AddrValid),
        .RdDataValid  (RdDataValid),
        .RdData       (RdData),
        .Busy         (Busy),
        .Underrun     (Underrun)
    );

    int          errors = 0;
    int          checks = 0;
    logic [17:0] expAddrQ [$];
    logic [14:0] expPixQ [$];
    int          burstsStarted = 0;
    int          wordIdx = 0;
    int          abortAt = 0;
    logic        abortFlag = 1'b0;
    int          delays [3] = '{0, 1, 7};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // SRAM controller model: accepts the address after a varying delay, then returns 16 words.
    initial begin : sramModel
        logic [17:0] addr0;
        int          dly;
        AddrValid   = 1'b0;
        RdDataValid = 1'b0;
        RdData      = '0;
        forever begin
            if (ReqBurstRead === 1'b1 && Reset === 1'b0) begin
                addr0 = RdAddress;
                if (expAddrQ.size() == 0) begin
                    check("addr_unexpected", 32'(addr0), 32'hFFFF_FFFF);
                end else begin
                    check("burst_addr", 32'(addr0), 32'(expAddrQ.pop_front()));
                end
                dly = delays[burstsStarted % 3];
                burstsStarted++;
                wordIdx = 0;
                repeat (dly) begin
                    @(negedge Clock);
                    check("addr_stable", 32'(RdAddress), 32'(addr0));
                    check("req_held", 32'(ReqBurstRead), 32'd1);
                end
                AddrValid = 1'b1;
                @(negedge Clock);
                AddrValid = 1'b0;
                check("req_drop", 32'(ReqBurstRead), 32'd0);
                for (int k = 0; k < 16; k++) begin
                    if (abortAt != 0 && k == abortAt) abortFlag = 1'b1;
                    RdDataValid = 1'b1;
                    RdData      = {1'($urandom), 15'(addr0 + 18'(k))};
                    wordIdx     = k + 1;
                    @(negedge Clock);
                    RdDataValid = 1'b0;
                    if (k < 15) begin
                        check("no_req_in_data", 32'(ReqBurstRead), 32'd0);
                        if (abortAt == 0) check("busy_in_data", 32'(Busy), 32'd1);
                        if ((burstsStarted % 2) == 0) @(negedge Clock);
                    end
                end
                abortAt = 0;
            end else begin
                @(negedge Clock);
            end
        end
    end

    task automatic pulseLineStart(input logic [7:0] y, input logic [1:0] scr);
        LineY        = y;
        ActiveScreen = scr;
        LineStart    = 1'b1;
        @(negedge Clock);
        LineStart    = 1'b0;
    endtask

    task automatic pushLine(input logic [17:0] base);
        for (int b = 0; b < 20; b++) expAddrQ.push_back(base + 18'(b * 16));
    endtask

    task automatic waitIdle(input string tag, input int maxCycles);
        int n;
        n = 0;
        while (Busy !== 1'b0 && n < maxCycles) begin
            @(negedge Clock);
            n++;
        end
        check({"idle_", tag}, 32'(Busy), 32'd0);
        check({"addr_drained_", tag}, 32'(expAddrQ.size()), 32'd0);
    endtask

    task automatic sweep(input logic [17:0] base);
        for (int i = 0; i <= 331; i++) begin
            if (i > 0) check($sformatf("pixel%0d", i - 1), 32'(PixelOut), 32'(expPixQ.pop_front()));
            if (i <= 330) begin
                PixelX = 9'(i);
                expPixQ.push_back((i < 320) ? 15'(base + 18'(i)) : 15'd0);
                @(negedge Clock);
            end
        end
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog expired");
    end

    initial begin : mainSeq
        int n;
        Reset        = 1'b1;
        LineStart    = 1'b0;
        LineY        = '0;
        ActiveScreen = '0;
        PixelX       = '0;
        repeat (3) @(negedge Clock);
        check("rst_req", 32'(ReqBurstRead), 32'd0);
        check("rst_addr", 32'(RdAddress), 32'd0);
        check("rst_busy", 32'(Busy), 32'd0);
        check("rst_underrun", 32'(Underrun), 32'd0);
        check("rst_pixel", 32'(PixelOut), 32'd0);
        Reset = 1'b0;
        @(negedge Clock);

        // Line 0 of screen 1 with address-accept delays 0, 1, 7.
        burstsStarted = 0;
        pushLine(18'd76800);
        pulseLineStart(8'd0, 2'd1);
        check("busy_rise", 32'(Busy), 32'd1);
        waitIdle("line0_scr1", 3000);
        check("bursts_line0", 32'(burstsStarted), 32'd20);
        check("underrun_clear", 32'(Underrun), 32'd0);

        // Screen 3 aliases screen 0; display the previous line while this one fills.
        burstsStarted = 0;
        pushLine(18'd0);
        pulseLineStart(8'd0, 2'd3);
        sweep(18'd76800);
        waitIdle("line0_scr3", 3000);

        // Out-of-range line: swap only.
        pulseLineStart(8'd240, 2'd0);
        repeat (4) begin
            check("no_req_240", 32'(ReqBurstRead), 32'd0);
            check("busy_240", 32'(Busy), 32'd0);
            @(negedge Clock);
        end
        sweep(18'd0);

        // LineStart in the middle of the 5th burst.
        burstsStarted = 0;
        pushLine(18'd156800);
        pulseLineStart(8'd10, 2'd2);
        n = 0;
        while (!(burstsStarted == 5 && wordIdx >= 8) && n < 2000) begin
            @(negedge Clock);
            n++;
        end
        check("reach_burst5", 32'(burstsStarted), 32'd5);
        expAddrQ.delete();
        pushLine(18'd6400);
        pulseLineStart(8'd20, 2'd0);
        check("underrun_set", 32'(Underrun), 32'd1);
        check("busy_restart", 32'(Busy), 32'd1);
        waitIdle("restart", 3000);
        pulseLineStart(8'd240, 2'd0);
        sweep(18'd6400);
        check("underrun_sticky", 32'(Underrun), 32'd1);

        // Reset in the middle of a burst.
        burstsStarted = 0;
        pushLine(18'd78400);
        abortFlag = 1'b0;
        abortAt   = 3;
        pulseLineStart(8'd5, 2'd1);
        n = 0;
        while (!abortFlag && n < 500) begin
            @(negedge Clock);
            n++;
        end
        check("abort_reached", 32'(abortFlag), 32'd1);
        Reset = 1'b1;
        @(negedge Clock);
        Reset = 1'b0;
        expAddrQ.delete();
        check("mid_rst_req", 32'(ReqBurstRead), 32'd0);
        check("mid_rst_busy", 32'(Busy), 32'd0);
        check("mid_rst_addr", 32'(RdAddress), 32'd0);
        check("mid_rst_underrun", 32'(Underrun), 32'd0);
        repeat (30) @(negedge Clock);
        check("post_rst_req", 32'(ReqBurstRead), 32'd0);
        check("post_rst_busy", 32'(Busy), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
